// File: rtl/cpu_frame_pkg.sv
// Shared definitions for the frame-pointer sequencer and the EBP/ESP registers
// that consume its write-command bus.
package cpu_frame_pkg;

  // Byte adjustment applied to ESP for each push or pop
  localparam int STACK_STEP = 4;

  // Opcodes issued by the decoder; 5-7 are illegal
  typedef enum logic [2:0] {
    OP_NOP         = 3'd0,
    OP_PUSH_EBP    = 3'd1,
    OP_MOV_EBP_ESP = 3'd2,
    OP_POP_EBP     = 3'd3,
    OP_LEAVE       = 3'd4
  } op_t;

  // Register write-command codes shared with the EBP and ESP registers
  localparam logic [3:0] RW_NONE = 4'h0;
  localparam logic [3:0] RW_ESP  = 4'h1;
  localparam logic [3:0] RW_EBP  = 4'h2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MEM_WR    = 3'd1,
    ST_MEM_RD    = 3'd2,
    ST_WB_ESP    = 3'd3,
    ST_WB_EBP    = 3'd4,
    ST_LEAVE_ESP = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  // Stack accesses are word-sized, so the two low address bits must be clear
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/frame_timeout_counter.sv
// Counts consecutive unacknowledged memory-request cycles and flags the cycle
// in which the wait reaches TIMEOUT. Clear has priority over enable.
module frame_timeout_counter
  import cpu_frame_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clock_5,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  // Expiry fires during the TIMEOUT-th waiting cycle so the owner can drop
  // its request on the following edge.
  assign o_expired = i_enable && (r_count == TERM_CNT);

  // Elapsed-wait counter; holds at the terminal count
  always_ff @(posedge clock_5 or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/stack_frame_sequencer.sv
// Multi-cycle sequencer for PUSH EBP, MOV EBP,ESP, POP EBP and LEAVE.
// Drives the shared EBP/ESP write-command bus and a req/ack stack memory port.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for start; latches operands and checks the op
// MEM_WR     | PUSH store of EBP to esp-STEP, held until ack
// MEM_RD     | POP load from esp, held until ack; load data goes to EBP
// WB_ESP     | rw_code = ESP write (PUSH new top, POP new top)
// WB_EBP     | rw_code = EBP write (MOV copy, or loaded value on POP)
// LEAVE_ESP  | rw_code = ESP write of EBP, then continue as POP
// DONE       | one-cycle done pulse, err flags a fault
//
// All outputs are registered: each transition loads the outputs belonging to
// the state being entered.
module stack_frame_sequencer
  import cpu_frame_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int STACK_STEP = cpu_frame_pkg::STACK_STEP,
  parameter int TIMEOUT    = 255
) (
  input  logic             clock_5,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] esp_in,
  input  logic [WIDTH-1:0] ebp_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [3:0]       rw_code,
  output logic [WIDTH-1:0] write_data,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(STACK_STEP);

  state_t           r_state;
  logic [WIDTH-1:0] r_esp_s;
  logic [WIDTH-1:0] r_ebp_s;
  logic [2:0]       r_op_s;

  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [3:0]       r_rw_code;
  logic [WIDTH-1:0] r_write_data;
  logic             r_mem_req;
  logic             r_mem_we;
  logic [WIDTH-1:0] r_mem_addr;
  logic [WIDTH-1:0] r_mem_wdata;

  logic             w_mem_state;
  logic             w_to_clear;
  logic             w_to_enable;
  logic             w_to_expired;
  logic [WIDTH-1:0] w_push_addr;

  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign rw_code    = r_rw_code;
  assign write_data = r_write_data;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

  // Modulo-2^WIDTH arithmetic: esp 0 pushes to the top of the address space
  assign w_push_addr = esp_in - STEP;

  // Only unacknowledged request cycles count toward the timeout
  assign w_mem_state = (r_state == ST_MEM_WR) || (r_state == ST_MEM_RD);
  assign w_to_clear  = !w_mem_state || mem_ack;
  assign w_to_enable = w_mem_state && r_mem_req && !mem_ack;

  frame_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clock_5   (clock_5),
    .reset     (reset),
    .i_clear   (w_to_clear),
    .i_enable  (w_to_enable),
    .o_expired (w_to_expired)
  );

  // Sequencer FSM with registered outputs
  always_ff @(posedge clock_5 or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_esp_s      <= '0;
      r_ebp_s      <= '0;
      r_op_s       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_rw_code    <= RW_NONE;
      r_write_data <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      // Pulse-type outputs default low every cycle
      r_rw_code <= RW_NONE;
      r_done    <= 1'b0;
      r_err     <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_esp_s <= esp_in;
            r_ebp_s <= ebp_in;
            r_op_s  <= op;
            r_busy  <= 1'b1;
            case (op)
              OP_NOP: begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end
              OP_PUSH_EBP: begin
                if (is_misaligned(w_push_addr[1:0])) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                  r_err   <= 1'b1;
                end else begin
                  r_state     <= ST_MEM_WR;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b1;
                  r_mem_addr  <= w_push_addr;
                  r_mem_wdata <= ebp_in;
                end
              end
              OP_MOV_EBP_ESP: begin
                r_state      <= ST_WB_EBP;
                r_rw_code    <= RW_EBP;
                r_write_data <= esp_in;
              end
              OP_POP_EBP: begin
                if (is_misaligned(esp_in[1:0])) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                  r_err   <= 1'b1;
                end else begin
                  r_state    <= ST_MEM_RD;
                  r_mem_req  <= 1'b1;
                  r_mem_we   <= 1'b0;
                  r_mem_addr <= esp_in;
                end
              end
              OP_LEAVE: begin
                // LEAVE pops from the old frame base, so EBP is the address checked
                if (is_misaligned(ebp_in[1:0])) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                  r_err   <= 1'b1;
                end else begin
                  r_state      <= ST_LEAVE_ESP;
                  r_rw_code    <= RW_ESP;
                  r_write_data <= ebp_in;
                end
              end
              default: begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
                r_err   <= 1'b1;
              end
            endcase
          end
        end

        ST_MEM_WR: begin
          if (mem_ack) begin
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_state      <= ST_WB_ESP;
            r_rw_code    <= RW_ESP;
            r_write_data <= r_esp_s - STEP;
          end else if (w_to_expired) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_state   <= ST_DONE;
            r_done    <= 1'b1;
            r_err     <= 1'b1;
          end
        end

        ST_MEM_RD: begin
          // Load data is only valid with ack, so it goes straight onto the bus
          if (mem_ack) begin
            r_mem_req    <= 1'b0;
            r_state      <= ST_WB_EBP;
            r_rw_code    <= RW_EBP;
            r_write_data <= mem_rdata;
          end else if (w_to_expired) begin
            r_mem_req <= 1'b0;
            r_state   <= ST_DONE;
            r_done    <= 1'b1;
            r_err     <= 1'b1;
          end
        end

        ST_WB_EBP: begin
          if (r_op_s == OP_MOV_EBP_ESP) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state      <= ST_WB_ESP;
            r_rw_code    <= RW_ESP;
            r_write_data <= r_esp_s + STEP;
          end
        end

        ST_WB_ESP: begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end

        ST_LEAVE_ESP: begin
          // ESP now equals the old EBP; the rest is an ordinary POP from there
          r_esp_s    <= r_ebp_s;
          r_state    <= ST_MEM_RD;
          r_mem_req  <= 1'b1;
          r_mem_we   <= 1'b0;
          r_mem_addr <= r_ebp_s;
        end

        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_frame_sequencer.sv
// Scoreboard bench: each test pushes expected register writes, memory requests
// and done/err results; a negedge monitor pops and compares them as they appear.
module tb_stack_frame_sequencer;

  logic        clock_5 = 1'b0;
  logic        reset   = 1'b0;
  logic        start   = 1'b0;
  logic [2:0]  op      = 3'd0;
  logic [31:0] esp_in  = '0;
  logic [31:0] ebp_in  = '0;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        busy, done, err, mem_req, mem_we;
  logic [3:0]  rw_code;
  logic [31:0] write_data, mem_addr, mem_wdata;

  always #5 clock_5 = ~clock_5;

  stack_frame_sequencer #(.WIDTH(32), .STACK_STEP(4), .TIMEOUT(255)) dut (
    .clock_5    (clock_5),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .esp_in     (esp_in),
    .ebp_in     (ebp_in),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .rw_code    (rw_code),
    .write_data (write_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  typedef struct { logic [3:0] code; logic [31:0] data; } wr_t;
  typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } mem_t;

  wr_t  wq[$];
  mem_t mq[$];
  logic dq[$];

  int n_total = 0;
  int n_bad   = 0;
  int req_cycles = 0;
  int ack_wait = 0;
  bit ack_never = 1'b0;
  logic [31:0] rd_val = '0;

  // Memory responder: ack after ack_wait unacknowledged request cycles
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(negedge clock_5);
      if (reset && mem_req && !ack_never) begin
        if (wcnt >= ack_wait) begin
          mem_ack   = 1'b1;
          mem_rdata = rd_val;
          wcnt      = 0;
        end else begin
          mem_ack = 1'b0;
          mem_rdata = $urandom;
          wcnt++;
        end
      end else begin
        mem_ack = 1'b0;
        wcnt    = 0;
      end
    end
  end

  // Monitor: compares every observed write, request and completion to the queues
  initial begin
    logic        prev_req;
    logic [31:0] h_addr, h_wd;
    logic        h_we;
    wr_t  ew;
    mem_t em;
    logic ee;
    prev_req = 1'b0;
    h_addr = '0; h_wd = '0; h_we = 1'b0;
    forever begin
      @(negedge clock_5);
      if (!reset) begin
        prev_req = 1'b0;
      end else begin
        if (rw_code !== 4'h0) begin
          n_total++;
          if (wq.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_write: got code=%h data=%h, required no write", rw_code, write_data);
          end else begin
            ew = wq.pop_front();
            if (rw_code !== ew.code || write_data !== ew.data) begin
              n_bad++;
              $display("FAIL reg_write: got code=%h data=%h, required code=%h data=%h",
                       rw_code, write_data, ew.code, ew.data);
            end
          end
        end
        if (mem_req === 1'b1) begin
          req_cycles++;
          n_total++;
          if (!prev_req) begin
            if (mq.size() == 0) begin
              n_bad++;
              $display("FAIL unexpected_req: got addr=%h we=%b, required no request", mem_addr, mem_we);
            end else begin
              em = mq.pop_front();
              if (mem_addr !== em.addr || mem_we !== em.we || (em.we && mem_wdata !== em.wdata)) begin
                n_bad++;
                $display("FAIL mem_req: got addr=%h we=%b wdata=%h, required addr=%h we=%b wdata=%h",
                         mem_addr, mem_we, mem_wdata, em.addr, em.we, em.wdata);
              end
            end
          end else if (mem_addr !== h_addr || mem_we !== h_we || mem_wdata !== h_wd) begin
            n_bad++;
            $display("FAIL req_stable: got addr=%h we=%b wdata=%h, required addr=%h we=%b wdata=%h",
                     mem_addr, mem_we, mem_wdata, h_addr, h_we, h_wd);
          end
          h_addr = mem_addr; h_we = mem_we; h_wd = mem_wdata;
        end
        prev_req = mem_req;
        if (done === 1'b1) begin
          n_total++;
          if (dq.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_done: got done=1 err=%b, required no done", err);
          end else begin
            ee = dq.pop_front();
            if (err !== ee || busy !== 1'b1) begin
              n_bad++;
              $display("FAIL done_err: got err=%b busy=%b, required err=%b busy=1", err, busy, ee);
            end
          end
        end else if (err !== 1'b0) begin
          n_total++;
          n_bad++;
          $display("FAIL err_without_done: got err=%b, required 0", err);
        end
      end
    end
  end

  // Issue one start pulse and wait (bounded) for done; cyc = cycle of done after edge 0
  task automatic run_op(input logic [2:0] o, input logic [31:0] esp, input logic [31:0] ebp,
                        input int max_cyc, output int cyc);
    req_cycles = 0;
    @(negedge clock_5);
    start = 1'b1; op = o; esp_in = esp; ebp_in = ebp;
    @(negedge clock_5);
    start = 1'b0; op = 3'd0; esp_in = $urandom; ebp_in = $urandom;
    cyc = 1;
    while (done !== 1'b1 && cyc < max_cyc) begin
      @(negedge clock_5);
      cyc++;
    end
    if (done !== 1'b1) begin
      n_total++;
      n_bad++;
      $display("FAIL done_wait: no done after %0d cycles, required done", cyc);
    end
  endtask

  task automatic test_reset();
    #3;
    n_total++;
    if ({busy, done, err, rw_code, write_data, mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b rw=%h req=%b addr=%h, required all 0",
               busy, done, rw_code, mem_req, mem_addr);
    end
    repeat (3) @(negedge clock_5);
    reset = 1'b1;
    repeat (2) @(negedge clock_5);
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic check_drained(input string name);
    n_total++;
    if (wq.size() != 0 || mq.size() != 0 || dq.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drained: got pending wr=%0d mem=%0d done=%0d, required 0 0 0",
               name, wq.size(), mq.size(), dq.size());
    end
  endtask

  task automatic test_mov();
    int cyc;
    wq.push_back('{4'h2, 32'h0000_1000});
    dq.push_back(1'b0);
    run_op(3'd2, 32'h0000_1000, 32'h1111_2222, 20, cyc);
    n_total++;
    if (cyc != 2 || req_cycles != 0) begin
      n_bad++;
      $display("FAIL mov_latency: got done_cycle=%0d req_cycles=%0d, required 2 0", cyc, req_cycles);
    end
    @(negedge clock_5);
    n_total++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mov_busy_after: got busy=%b, required 0", busy);
    end
    check_drained("mov");
  endtask

  task automatic test_push();
    int cyc;
    ack_wait = 3;
    mq.push_back('{32'h0000_0FFC, 1'b1, 32'hCAFE_0001});
    wq.push_back('{4'h1, 32'h0000_0FFC});
    dq.push_back(1'b0);
    run_op(3'd1, 32'h0000_1000, 32'hCAFE_0001, 40, cyc);
    n_total++;
    if (cyc != 6 || req_cycles != 4) begin
      n_bad++;
      $display("FAIL push_wait_latency: got done_cycle=%0d req_cycles=%0d, required 6 4", cyc, req_cycles);
    end
    check_drained("push");
    // zero-wait push with esp 0 wraps to the top of memory
    ack_wait = 0;
    mq.push_back('{32'hFFFF_FFFC, 1'b1, 32'h0BAD_F00D});
    wq.push_back('{4'h1, 32'hFFFF_FFFC});
    dq.push_back(1'b0);
    run_op(3'd1, 32'h0000_0000, 32'h0BAD_F00D, 40, cyc);
    n_total++;
    if (cyc != 3) begin
      n_bad++;
      $display("FAIL push_latency: got done_cycle=%0d, required 3", cyc);
    end
    check_drained("push_wrap");
  endtask

  task automatic test_pop_wrap();
    int cyc;
    ack_wait = 0;
    rd_val = 32'h1234_5678;
    mq.push_back('{32'hFFFF_FFFC, 1'b0, 32'h0});
    wq.push_back('{4'h2, 32'h1234_5678});
    wq.push_back('{4'h1, 32'h0000_0000});
    dq.push_back(1'b0);
    run_op(3'd3, 32'hFFFF_FFFC, 32'h0000_0040, 40, cyc);
    n_total++;
    if (cyc != 4) begin
      n_bad++;
      $display("FAIL pop_latency: got done_cycle=%0d, required 4", cyc);
    end
    check_drained("pop_wrap");
  endtask

  task automatic test_leave();
    int cyc;
    ack_wait = 0;
    rd_val = 32'h0000_3000;
    wq.push_back('{4'h1, 32'h0000_2000});
    mq.push_back('{32'h0000_2000, 1'b0, 32'h0});
    wq.push_back('{4'h2, 32'h0000_3000});
    wq.push_back('{4'h1, 32'h0000_2004});
    dq.push_back(1'b0);
    run_op(3'd4, 32'h0000_0500, 32'h0000_2000, 40, cyc);
    n_total++;
    if (cyc != 5) begin
      n_bad++;
      $display("FAIL leave_latency: got done_cycle=%0d, required 5", cyc);
    end
    check_drained("leave");
  endtask

  task automatic test_faults();
    int cyc;
    logic [2:0] ill;
    dq.push_back(1'b0);
    run_op(3'd0, 32'h0000_1000, 32'h0000_2000, 10, cyc);
    n_total++;
    if (cyc != 1) begin
      n_bad++;
      $display("FAIL nop_latency: got done_cycle=%0d, required 1", cyc);
    end
    for (int i = 5; i <= 7; i++) begin
      ill = 3'(i);
      dq.push_back(1'b1);
      run_op(ill, 32'h0000_1000, 32'h0000_2000, 10, cyc);
      n_total++;
      if (cyc != 1 || req_cycles != 0) begin
        n_bad++;
        $display("FAIL illegal_op%0d: got done_cycle=%0d req_cycles=%0d, required 1 0", i, cyc, req_cycles);
      end
    end
    dq.push_back(1'b1);
    run_op(3'd3, 32'h0000_1002, 32'h0000_2000, 10, cyc);
    n_total++;
    if (cyc != 1 || req_cycles != 0) begin
      n_bad++;
      $display("FAIL pop_misaligned: got done_cycle=%0d req_cycles=%0d, required 1 0", cyc, req_cycles);
    end
    dq.push_back(1'b1);
    run_op(3'd1, 32'h0000_1001, 32'h0000_2000, 10, cyc);
    n_total++;
    if (cyc != 1 || req_cycles != 0) begin
      n_bad++;
      $display("FAIL push_misaligned: got done_cycle=%0d req_cycles=%0d, required 1 0", cyc, req_cycles);
    end
    dq.push_back(1'b1);
    run_op(3'd4, 32'h0000_1000, 32'h0000_2003, 10, cyc);
    n_total++;
    if (cyc != 1 || req_cycles != 0) begin
      n_bad++;
      $display("FAIL leave_misaligned: got done_cycle=%0d req_cycles=%0d, required 1 0", cyc, req_cycles);
    end
    check_drained("faults");
  endtask

  task automatic test_timeout();
    int cyc;
    ack_never = 1'b1;
    mq.push_back('{32'h0000_4000, 1'b0, 32'h0});
    dq.push_back(1'b1);
    run_op(3'd3, 32'h0000_4000, 32'h0000_0000, 400, cyc);
    n_total++;
    if (cyc != 256 || req_cycles != 255) begin
      n_bad++;
      $display("FAIL pop_timeout: got done_cycle=%0d req_cycles=%0d, required 256 255", cyc, req_cycles);
    end
    ack_never = 1'b0;
    check_drained("timeout");
  endtask

  task automatic test_back_to_back();
    int cyc;
    ack_wait = 5;
    mq.push_back('{32'h0000_7FFC, 1'b1, 32'h5555_AAAA});
    wq.push_back('{4'h1, 32'h0000_7FFC});
    dq.push_back(1'b0);
    @(negedge clock_5);
    start = 1'b1; op = 3'd1; esp_in = 32'h0000_8000; ebp_in = 32'h5555_AAAA;
    @(negedge clock_5);
    start = 1'b0;
    @(negedge clock_5);
    start = 1'b1; op = 3'd2; esp_in = 32'h0000_9000;
    @(negedge clock_5);
    start = 1'b0; op = 3'd0;
    cyc = 3;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clock_5);
      cyc++;
    end
    n_total++;
    if (cyc != 8) begin
      n_bad++;
      $display("FAIL busy_start_ignored: got done_cycle=%0d, required 8", cyc);
    end
    // next op starts right after the DONE cycle
    ack_wait = 0;
    wq.push_back('{4'h2, 32'h0000_9000});
    dq.push_back(1'b0);
    run_op(3'd2, 32'h0000_9000, 32'h0, 20, cyc);
    n_total++;
    if (cyc != 2) begin
      n_bad++;
      $display("FAIL back_to_back_mov: got done_cycle=%0d, required 2", cyc);
    end
    check_drained("back_to_back");
  endtask

  task automatic test_reset_mid();
    int cyc;
    ack_wait = 50;
    mq.push_back('{32'h0000_1FFC, 1'b1, 32'h7777_0000});
    @(negedge clock_5);
    start = 1'b1; op = 3'd1; esp_in = 32'h0000_2000; ebp_in = 32'h7777_0000;
    @(negedge clock_5);
    start = 1'b0; op = 3'd0;
    repeat (3) @(negedge clock_5);
    #2 reset = 1'b0;
    #1;
    n_total++;
    if ({busy, done, err, rw_code, write_data, mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: got busy=%b req=%b we=%b addr=%h rw=%h, required all 0",
               busy, mem_req, mem_we, mem_addr, rw_code);
    end
    repeat (2) @(negedge clock_5);
    reset = 1'b1;
    ack_wait = 0;
    repeat (10) @(negedge clock_5);
    wq.push_back('{4'h2, 32'h0000_0ABC});
    dq.push_back(1'b0);
    run_op(3'd2, 32'h0000_0ABC, 32'h0, 20, cyc);
    n_total++;
    if (cyc != 2) begin
      n_bad++;
      $display("FAIL mov_after_reset: got done_cycle=%0d, required 2", cyc);
    end
    check_drained("reset_mid");
  endtask

  initial begin
    test_reset();
    test_mov();
    test_push();
    test_pop_wrap();
    test_leave();
    test_faults();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clock_5);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/stack_frame_sequencer.md
Name: stack_frame_sequencer

Overview:
- Multi-cycle sequencer that executes the frame-pointer instructions PUSH EBP, MOV EBP,ESP, POP EBP and LEAVE.
- Sits directly upstream of the EBP register and the ESP register, and drives their shared write-command bus (rw_code, write_data).
- Also drives a req/ack data-memory port for the stack access.
- The decoder starts it with a one-cycle start pulse. It reports completion with done, and reports faults with err.

Parameters:
- WIDTH, 32, datapath/address width.
- STACK_STEP, 4, byte adjustment applied to ESP per push/pop.
- TIMEOUT, 255, maximum number of cycles to wait for mem_ack before aborting.

Ports:
- clock_5  input  1  system clock; rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  one-cycle request; sampled only in IDLE.
- op  input  3  0 NOP, 1 PUSH_EBP, 2 MOV_EBP_ESP, 3 POP_EBP, 4 LEAVE, 5-7 illegal.
- esp_in  input  WIDTH  current ESP.
- ebp_in  input  WIDTH  current EBP.
- busy  output  1  high from the cycle after start is accepted through the DONE cycle.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done: illegal op, misaligned address, or timeout.
- rw_code  output  4  4'h0 no write, 4'h1 write ESP, 4'h2 write EBP; nonzero for exactly one cycle per write.
- write_data  output  WIDTH  value for the register selected by rw_code.
- mem_req  output  1  memory request.
- mem_we  output  1  1 = write, 0 = read.
- mem_addr  output  WIDTH  byte address.
- mem_wdata  output  WIDTH  store data.
- mem_rdata  input  WIDTH  load data; valid in the cycle mem_ack is high.
- mem_ack  input  1  transfer complete; ignored while mem_req is low.

Behaviour:
- Reset (asynchronous, while reset is low):
  - state = IDLE.
  - All outputs = 0.
  - Shadow registers and the timeout counter = 0.
  - Any memory transaction in flight is abandoned; no register write is issued afterwards.
- On accepting start in IDLE:
  - Latch esp_s = esp_in, ebp_s = ebp_in, op_s = op.
  - start while busy is ignored.
  - start with op = NOP produces done in the next cycle with no writes.
- States:
  - IDLE, MEM_WR, MEM_RD, WB_ESP, WB_EBP, LEAVE_ESP, DONE.
- Transitions by op:
  - PUSH_EBP: MEM_WR (addr = esp_s-4, wdata = ebp_s, we = 1) -> WB_ESP (rw_code 1, data = esp_s-4) -> DONE.
  - MOV_EBP_ESP: WB_EBP (rw_code 2, data = esp_s) -> DONE.
  - POP_EBP: MEM_RD (addr = esp_s, we = 0), capturing mem_rdata on ack -> WB_EBP (rw_code 2, data = captured value) -> WB_ESP (rw_code 1, data = esp_s+4) -> DONE.
  - LEAVE: LEAVE_ESP (rw_code 1, data = ebp_s; set esp_s = ebp_s) -> then the POP_EBP sequence.
- Memory handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until mem_ack is sampled high.
  - mem_ack may arrive in the first req cycle.
  - On ack, mem_req deasserts in the next cycle.
- Latency with zero-wait memory (start sampled at edge 0):
  - MOV: rw_code at cycle 1, done at cycle 2.
  - PUSH: req at cycle 1, ESP write at cycle 2, done at cycle 3.
  - POP: done at cycle 4.
  - LEAVE: done at cycle 5.
- Arithmetic: all address math is modulo 2^WIDTH.
  - esp_s = 0 on PUSH gives addr 0xFFFF_FFFC.
  - esp_s = 0xFFFF_FFFC on POP gives new ESP 0x0000_0000.
- Faults: each fault leads to DONE with err = 1.
  - Illegal op (5-7): DONE in the next cycle, no writes, no mem_req.
  - Misaligned address: checked at acceptance on the first memory address (PUSH: esp_in-4; POP: esp_in; LEAVE: ebp_in). If bits [1:0] != 0, no writes and no mem_req.
  - Timeout: counter counts mem_req cycles without ack. When it reaches TIMEOUT, mem_req drops and the block goes to DONE with no further writes. Writes already issued (the LEAVE ESP write) are not undone.
- DONE lasts exactly one cycle (done = 1, busy = 1), then returns to IDLE.
- err is 0 except in a faulting DONE cycle.
- rw_code is never nonzero outside the WB_ESP, WB_EBP and LEAVE_ESP states.

Decomposition:
- Shared package cpu_frame_pkg holds:
  - op encodings;
  - rw_code constants (RW_NONE = 4'h0, RW_ESP = 4'h1, RW_EBP = 4'h2), shared with the EBP and ESP registers;
  - the state enum;
  - STACK_STEP.
- One sub-module: frame_timeout_counter (clear/enable inputs, expired output), reusable by other memory-waiting stages.

Test Plan:
- MOV: esp_in = 0x0000_1000, op = 2, start -> cycle 1 rw_code = 2, write_data = 0x1000; cycle 2 done = 1, err = 0; mem_req never asserted.
- PUSH: esp_in = 0x1000, ebp_in = 0xCAFE_0001, ack after 3 wait cycles -> mem write to addr 0x0FFC with data 0xCAFE_0001, then rw_code = 1 with data 0x0FFC, then done.
- LEAVE: ebp_in = 0x2000, mem_rdata = 0x3000 -> rw_code 1 / 0x2000, then read at 0x2000, then rw_code 2 / 0x3000, then rw_code 1 / 0x2004, then done.
- Faults:
  - op = 6 -> done + err next cycle, no writes.
  - POP with esp_in = 0x1002 -> done + err, no mem_req.
  - POP with mem_ack held low -> mem_req for 255 cycles, then done + err, rw_code stays 0.
- Wrap: POP with esp_in = 0xFFFF_FFFC -> ESP write data = 0x0000_0000.
- Reset low in the middle of PUSH (during the mem wait) -> all outputs 0 immediately; after release, no write is issued and a new MOV start completes normally.
